// File: rtl/dmem_responder_pkg.sv
// Shared decode/memory definitions: access-size encodings, opcode constants,
// the data-memory responder state enum and small lane helpers.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    // Byte-lane mask of an access before shifting by the byte offset.
    // The reserved encoding behaves as a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 4'h1;
            SZ_HALF: lane_mask = 4'h3;
            default: lane_mask = 4'hF;
        endcase
    endfunction

    // True when the access crosses a word boundary and needs two SRAM cycles.
    function automatic logic access_splits(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: access_splits = 1'b0;
            SZ_HALF: access_splits = (off == 2'd3);
            default: access_splits = (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane datapath: store lane enables/data for either half of a
// (possibly split) access, and load merge plus sign/zero extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        second,
    input  logic        split,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] sram_rdata,
    input  logic [31:0] held,
    output logic [3:0]  lane_be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] raw;

    // Shift the request across an 8-lane window; the upper half feeds the second word.
    always_comb begin
        shamt      = {off, 3'b000};
        mask8      = {4'h0, lane_mask(size)} << off;
        wide       = {32'h0, wdata} << shamt;
        lane_be    = second ? mask8[7:4] : mask8[3:0];
        lane_wdata = second ? wide[63:32] : wide[31:0];
    end

    // Merge the held first word with the current read word, then extend.
    always_comb begin
        if (split) begin
            raw = 32'({sram_rdata, held} >> shamt);
        end else begin
            raw = sram_rdata >> shamt;
        end
        case (size)
            SZ_BYTE: load_data = {{24{~load_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: load_data = {{16{~load_unsigned & raw[15]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: accepts one request at a time, performs one
// or two SRAM word accesses (split when unaligned across a word boundary) and
// returns a single-cycle completion pulse with extended load data.
module dmem_responder #(
    parameter int SRAM_AW = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               mem_r_w,
    input  logic [1:0]         mem_access_size,
    input  logic               mem_load_unsigned,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               rsp_valid,
    output logic [31:0]        rdata,
    output logic               sram_en,
    output logic [3:0]         sram_be,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);
    import dmem_responder_pkg::*;

    dmem_state_t        state_reg;
    dmem_state_t        state_next;
    logic               load_reg;
    logic [1:0]         size_reg;
    logic               unsigned_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        held_reg;

    logic               split;
    logic [SRAM_AW-1:0] word_index;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        load_data;

    assign split      = access_splits(size_reg, addr_reg[1:0]);
    assign word_index = addr_reg[SRAM_AW+1:2];

    dmem_lane_align u_align (
        .size          (size_reg),
        .off           (addr_reg[1:0]),
        .second        (state_reg == SECOND),
        .split         (split),
        .load_unsigned (unsigned_reg),
        .wdata         (wdata_reg),
        .sram_rdata    (sram_rdata),
        .held          (held_reg),
        .lane_be       (lane_be),
        .lane_wdata    (lane_wdata),
        .load_data     (load_data)
    );

    // State register; reset abandons whatever access is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the request on the accept edge; inputs are ignored otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_reg     <= 1'b0;
            size_reg     <= SZ_BYTE;
            unsigned_reg <= 1'b0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
        end else if (state_reg == IDLE && req_valid) begin
            load_reg     <= mem_r_w;
            size_reg     <= mem_access_size;
            unsigned_reg <= mem_load_unsigned;
            addr_reg     <= addr;
            wdata_reg    <= wdata;
        end
    end

    // Hold the first word of a split load while the second word is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_reg <= 32'h0;
        end else if (state_reg == SECOND && load_reg) begin
            held_reg <= sram_rdata;
        end
    end

    // Next-state sequencing: one or two SRAM cycles, then a response cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = FIRST;
            FIRST:   state_next = split ? SECOND : RESP;
            SECOND:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; SRAM buses are quiet whenever sram_en is low.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rdata      = 32'h0;
        sram_en    = 1'b0;
        sram_be    = 4'h0;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        case (state_reg)
            IDLE: begin
                req_ready = ~reset;
            end
            FIRST, SECOND: begin
                sram_en   = 1'b1;
                sram_addr = (state_reg == SECOND) ? word_index + SRAM_AW'(1) : word_index;
                if (!load_reg) begin
                    sram_be    = lane_be;
                    sram_wdata = lane_wdata;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (load_reg) begin
                    rdata = load_data;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural word SRAM.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_r_w;
    logic [1:0]  mem_access_size;
    logic        mem_load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        sram_en;
    logic [3:0]  sram_be;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.SRAM_AW(30)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .mem_r_w           (mem_r_w),
        .mem_access_size   (mem_access_size),
        .mem_load_unsigned (mem_load_unsigned),
        .addr              (addr),
        .wdata             (wdata),
        .rsp_valid         (rsp_valid),
        .rdata             (rdata),
        .sram_en           (sram_en),
        .sram_be           (sram_be),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte-lane writes, registered reads.
    logic [31:0] mem [logic [29:0]];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_be == 4'h0) begin
                sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
            end else begin
                logic [31:0] w;
                w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr] = w;
            end
        end
    end

    // Per-cycle snapshot of the DUT after an accept edge (k = 0 is the first cycle).
    logic        cap_en   [4];
    logic [3:0]  cap_be   [4];
    logic [29:0] cap_addr [4];
    logic [31:0] cap_wd   [4];
    logic        cap_rsp  [4];
    logic [31:0] cap_rd   [4];
    logic        cap_rdy  [4];

    task automatic run(input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int waited;
        waited            = 0;
        mem_r_w           = rw;
        mem_access_size   = sz;
        mem_load_unsigned = uns;
        addr              = a;
        wdata             = wd;
        req_valid         = 1'b1;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout got req_ready=%b required=1", req_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cap_en[k]   = sram_en;
            cap_be[k]   = sram_be;
            cap_addr[k] = sram_addr;
            cap_wd[k]   = sram_wdata;
            cap_rsp[k]  = rsp_valid;
            cap_rd[k]   = rdata;
            cap_rdy[k]  = req_ready;
        end
        $display("txn %s size=%0d uns=%0d addr=%h wdata=%h rsp=%b%b%b rdata=%h",
                 rw ? "load " : "store", sz, uns, a, wd, cap_rsp[0], cap_rsp[1], cap_rsp[2],
                 cap_rsp[1] ? cap_rd[1] : cap_rd[2]);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; mem_r_w = 1'b0; mem_access_size = 2'd0;
        mem_load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rdata, sram_en, sram_be, sram_addr, sram_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b rsp=%b en=%b be=%h required all 0",
                     req_ready, rsp_valid, sram_en, sram_be);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", req_ready);
        end
    endtask

    task automatic test_word_store();
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if ({cap_en[0], cap_addr[0], cap_be[0], cap_wd[0]} !== {1'b1, 30'h40, 4'hF, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL ws_first got en=%b addr=%h be=%h wd=%h required 1/40/f/deadbeef",
                     cap_en[0], cap_addr[0], cap_be[0], cap_wd[0]);
        end
        checks++;
        if ({cap_rsp[0], cap_rsp[1], cap_en[1], cap_be[1], cap_rd[1]} !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL ws_resp got rsp0=%b rsp1=%b en1=%b be1=%h rd1=%h required 0/1/0/0/0",
                     cap_rsp[0], cap_rsp[1], cap_en[1], cap_be[1], cap_rd[1]);
        end
        run(1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        checks++;
        if ({cap_be[0], cap_rd[1]} !== {4'h0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL ws_readback got be=%h rdata=%h required 0/deadbeef", cap_be[0], cap_rd[1]);
        end
    endtask

    task automatic test_byte_access();
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h12F4_5678, 1'b0);
        run(1'b1, SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0, 1'b0);
        checks++;
        if ({cap_rd[0], cap_rd[1]} !== {32'h0, 32'hFFFF_FFF4}) begin
            failures++;
            $display("FAIL lb_signed got rd0=%h rd1=%h required 0/fffffff4", cap_rd[0], cap_rd[1]);
        end
        run(1'b1, SZ_BYTE, 1'b1, 32'h0000_0102, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'h0000_00F4) begin
            failures++;
            $display("FAIL lb_unsigned got=%h required=000000f4", cap_rd[1]);
        end
        run(1'b0, SZ_BYTE, 1'b0, 32'h0000_0105, 32'h0000_00EE, 1'b0);
        checks++;
        if ({cap_addr[0], cap_be[0], cap_wd[0], cap_rsp[1]} !== {30'h41, 4'h2, 32'h0000_EE00, 1'b1}) begin
            failures++;
            $display("FAIL sb_off1 got addr=%h be=%h wd=%h rsp=%b required 41/2/0000ee00/1",
                     cap_addr[0], cap_be[0], cap_wd[0], cap_rsp[1]);
        end
    endtask

    task automatic test_split_half_store();
        run(1'b0, SZ_HALF, 1'b0, 32'h0000_0103, 32'h0000_ABCD, 1'b0);
        checks++;
        if ({cap_addr[0], cap_be[0], cap_wd[0]} !== {30'h40, 4'h8, 32'hCD00_0000}) begin
            failures++;
            $display("FAIL sh_first got addr=%h be=%h wd=%h required 40/8/cd000000",
                     cap_addr[0], cap_be[0], cap_wd[0]);
        end
        checks++;
        if ({cap_en[1], cap_addr[1], cap_be[1], cap_wd[1]} !== {1'b1, 30'h41, 4'h1, 32'h0000_00AB}) begin
            failures++;
            $display("FAIL sh_second got en=%b addr=%h be=%h wd=%h required 1/41/1/000000ab",
                     cap_en[1], cap_addr[1], cap_be[1], cap_wd[1]);
        end
        checks++;
        if ({cap_rsp[1], cap_rsp[2]} !== 2'b01) begin
            failures++;
            $display("FAIL sh_latency got rsp1=%b rsp2=%b required 0/1", cap_rsp[1], cap_rsp[2]);
        end
        run(1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'hCDF4_5678) begin
            failures++;
            $display("FAIL sh_word0 got=%h required=cdf45678", cap_rd[1]);
        end
        run(1'b1, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'h0000_EEAB) begin
            failures++;
            $display("FAIL sh_word1 got=%h required=0000eeab", cap_rd[1]);
        end
    endtask

    task automatic test_half_load();
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0140, 32'h8001_9ABC, 1'b0);
        run(1'b1, SZ_HALF, 1'b0, 32'h0000_0142, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL lh_signed_hi got=%h required=ffff8001", cap_rd[1]);
        end
        run(1'b1, SZ_HALF, 1'b1, 32'h0000_0140, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'h0000_9ABC) begin
            failures++;
            $display("FAIL lh_unsigned got=%h required=00009abc", cap_rd[1]);
        end
        run(1'b1, SZ_HALF, 1'b0, 32'h0000_0140, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'hFFFF_9ABC) begin
            failures++;
            $display("FAIL lh_signed_lo got=%h required=ffff9abc", cap_rd[1]);
        end
    endtask

    task automatic test_split_word_load();
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h4433_2211, 1'b0);
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h8877_6655, 1'b0);
        run(1'b1, SZ_WORD, 1'b0, 32'h0000_0101, 32'h0, 1'b0);
        checks++;
        if ({cap_addr[0], cap_addr[1], cap_be[1], cap_rsp[1], cap_rsp[2]} !== {30'h40, 30'h41, 4'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lw_split_seq got a0=%h a1=%h be1=%h rsp1=%b rsp2=%b required 40/41/0/0/1",
                     cap_addr[0], cap_addr[1], cap_be[1], cap_rsp[1], cap_rsp[2]);
        end
        checks++;
        if (cap_rd[2] !== 32'h5544_3322) begin
            failures++;
            $display("FAIL lw_split_data got=%h required=55443322", cap_rd[2]);
        end
        run(1'b1, 2'd3, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
        checks++;
        if (cap_rd[1] !== 32'h4433_2211) begin
            failures++;
            $display("FAIL lw_reserved_size got=%h required=44332211", cap_rd[1]);
        end
    endtask

    task automatic test_wrap();
        run(1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'hAABB_CCDD, 1'b0);
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0000, 32'h1122_3344, 1'b0);
        run(1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
        checks++;
        if ({cap_addr[0], cap_addr[1]} !== {30'h3FFF_FFFF, 30'h0}) begin
            failures++;
            $display("FAIL wrap_index got a0=%h a1=%h required 3fffffff/0", cap_addr[0], cap_addr[1]);
        end
        checks++;
        if (cap_rd[2] !== 32'h3344_AABB) begin
            failures++;
            $display("FAIL wrap_data got=%h required=3344aabb", cap_rd[2]);
        end
    endtask

    task automatic test_back_to_back();
        run(1'b0, SZ_WORD, 1'b0, 32'h0000_0200, 32'h0BAD_F00D, 1'b1);
        checks++;
        if ({cap_rdy[1], cap_rdy[2], cap_en[3], cap_addr[3]} !== {1'b0, 1'b1, 1'b1, 30'h80}) begin
            failures++;
            $display("FAIL b2b_accept got rdy1=%b rdy2=%b en3=%b a3=%h required 0/1/1/80",
                     cap_rdy[1], cap_rdy[2], cap_en[3], cap_addr[3]);
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_resp got=%b required=1", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mem_r_w = 1'b1; mem_access_size = SZ_WORD; mem_load_unsigned = 1'b0;
        addr = 32'h0000_0101; wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sram_en, sram_addr} !== {1'b1, 30'h41}) begin
            failures++;
            $display("FAIL rst_mid_second got en=%b addr=%h required 1/41", sram_en, sram_addr);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rdata, sram_en, sram_be, sram_addr, sram_wdata} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got ready=%b rsp=%b en=%b addr=%h required all 0",
                     req_ready, rsp_valid, sram_en, sram_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_no_rsp got=%b required=0", rsp_valid);
            end
        end
        reset = 1'b0;
        mem_r_w = 1'b0; addr = 32'h0000_0108; wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b required=1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({sram_en, sram_addr, sram_be} !== {1'b1, 30'h42, 4'hF}) begin
            failures++;
            $display("FAIL rst_mid_accept got en=%b addr=%h be=%h required 1/42/f",
                     sram_en, sram_addr, sram_be);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_resp got=%b required=1", rsp_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_access();
        test_split_half_store();
        test_half_load();
        test_split_word_load();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
